// File: rtl/adder_io_pkg.sv
// Shared constants, state encoding and bus packing for the adder I/O stage.
package adder_io_pkg;

  localparam int WIDTH = 12;
  localparam int BUS_W = 2 * WIDTH;
  localparam int SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Adder netlist expects bit-interleaved operands: even bits A, odd bits B.
  function automatic logic [BUS_W-1:0] interleave(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_io_if.sv
// Operand/result handshakes, adder netlist bus and accumulator status.
interface adder_io_if;
  import adder_io_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc;
  logic             acc_clr;
  logic [BUS_W-1:0] add_in;
  logic [SUM_W-1:0] add_out;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_sticky;

  // Stage side.
  modport slave (
    input  in_valid, in_a, in_b, in_acc, acc_clr, add_out, out_ready,
    output in_ready, add_in, out_valid, out_sum, acc_q, ovf_sticky
  );

  // Environment side (upstream, downstream and the adder netlist).
  modport master (
    output in_valid, in_a, in_b, in_acc, acc_clr, add_out, out_ready,
    input  in_ready, add_in, out_valid, out_sum, acc_q, ovf_sticky
  );

endinterface

// File: rtl/adder_io_stage.sv
// Sequential wrapper around the combinational prefix adder: accepts an
// operand pair, drives the interleaved bus, waits ADD_LAT cycles, captures
// the sum and offers it downstream. Optional accumulate mode with sticky
// overflow.
//
// state | meaning
// IDLE  | ready for an operand pair
// WAIT  | adder inputs held, counting down the settle time
// HOLD  | sum captured and offered downstream
module adder_io_stage #(
  parameter int WIDTH   = adder_io_pkg::WIDTH,
  parameter int ADD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  adder_io_if.slave  bus
);
  import adder_io_pkg::*;

  localparam int CNT_W = 2;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               acc_flag_q, acc_flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_sticky_q, ovf_sticky_d;

  logic               in_ready;
  logic               accept;

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready   = in_ready;
  assign bus.add_in     = interleave(op_a_q, op_b_q);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.acc_q      = acc_q;
  assign bus.ovf_sticky = ovf_sticky_q;

  // Next-state, operand load, settle countdown and result capture.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    acc_flag_d   = acc_flag_q;
    cnt_d        = cnt_q;
    out_sum_d    = out_sum_q;
    out_valid_d  = out_valid_q;
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_sum_d   = bus.add_out;
          acc_d       = bus.add_out[WIDTH-1:0];
          if (acc_flag_q) begin
            ovf_sticky_d = ovf_sticky_q | bus.add_out[WIDTH];
          end
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? WAIT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand load is shared by IDLE and the back-to-back path out of HOLD;
    // acc_q read here already reflects any capture from the previous op.
    if (accept) begin
      op_a_d     = bus.in_a;
      op_b_d     = bus.in_acc ? (bus.acc_clr ? '0 : acc_q) : bus.in_b;
      acc_flag_d = bus.in_acc;
      cnt_d      = CNT_W'(ADD_LAT - 1);
    end

    // Clear wins over a same-cycle capture of the accumulator state.
    if (bus.acc_clr) begin
      acc_d        = '0;
      ovf_sticky_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      acc_flag_q   <= 1'b0;
      cnt_q        <= '0;
      out_sum_q    <= '0;
      out_valid_q  <= 1'b0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      acc_flag_q   <= acc_flag_d;
      cnt_q        <= cnt_d;
      out_sum_q    <= out_sum_d;
      out_valid_q  <= out_valid_d;
      acc_q        <= acc_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

endmodule

// File: tb/tb_adder_io_stage.sv
// Bench for adder_io_stage: two instances (ADD_LAT=1 and ADD_LAT=3), each
// with a behavioural model of the adder netlist on its bus.
module tb_adder_io_stage;
  import adder_io_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference accumulator state for the ADD_LAT=1 instance.
  logic [11:0] mdl_acc = '0;
  logic        mdl_ovf = 1'b0;

  always #5 clk = ~clk;

  adder_io_if bus1 ();
  adder_io_if bus3 ();

  adder_io_stage #(.ADD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  adder_io_stage #(.ADD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // Behavioural stand-in for the prefix adder netlist: de-interleave and add.
  function automatic logic [12:0] adder_net(input logic [23:0] v);
    logic [11:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a[i] = v[2*i];
      b[i] = v[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign bus1.add_out = adder_net(bus1.add_in);
  assign bus3.add_out = adder_net(bus3.add_in);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    mdl_acc = '0;
    mdl_ovf = 1'b0;
  endtask

  // Reference: one completed op, B replaced by the accumulator in acc mode.
  task automatic mdl_op(input logic [11:0] a, input logic [11:0] b, input logic acc,
                        output logic [12:0] s);
    logic [11:0] be;
    be = acc ? mdl_acc : b;
    s = {1'b0, a} + {1'b0, be};
    mdl_acc = s[11:0];
    if (acc) mdl_ovf = mdl_ovf | s[12];
  endtask

  task automatic drive(input int sel, input logic v, input logic [11:0] a,
                       input logic [11:0] b, input logic acc);
    if (sel == 1) begin
      bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b; bus1.in_acc = acc;
    end else begin
      bus3.in_valid = v; bus3.in_a = a; bus3.in_b = b; bus3.in_acc = acc;
    end
  endtask

  // Present a pair until accepted; returns at accept edge + 1.
  task automatic send(input int sel, input logic [11:0] a, input logic [11:0] b,
                      input logic acc);
    bit done = 0;
    drive(sel, 1'b1, a, b, acc);
    for (int i = 0; i < 50 && !done; i++) begin
      if ((sel == 1) ? bus1.in_ready : bus3.in_ready) done = 1;
      tick();
    end
    drive(sel, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL accept_timeout sel=%0d: in_ready never seen high", sel);
    end
  endtask

  task automatic wait_out(input int sel, output int cyc);
    cyc = 0;
    while (!((sel == 1) ? bus1.out_valid : bus3.out_valid) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take(input int sel);
    if (sel == 1) bus1.out_ready = 1'b1; else bus3.out_ready = 1'b1;
    tick();
    if (sel == 1) bus1.out_ready = 1'b0; else bus3.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (bus1.out_valid !== 1'b0 || bus1.out_sum !== 13'h0 || bus1.add_in !== 24'h0 ||
        bus1.acc_q !== 12'h0 || bus1.ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: ov=%b sum=%h add_in=%h acc=%h ovf=%b, required all zero",
               bus1.out_valid, bus1.out_sum, bus1.add_in, bus1.acc_q, bus1.ovf_sticky);
    end
    #21 rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus1.in_ready !== 1'b1 || bus3.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_ready: got %b/%b required 1/1", bus1.in_ready, bus3.in_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    logic [12:0] s;
    bus1.out_ready = 1'b1;
    send(1, 12'hFFF, 12'h001, 1'b0);
    mdl_op(12'hFFF, 12'h001, 1'b0, s);
    tests_run++;
    if (bus1.add_in !== 24'h555557 || bus1.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_add_in: add_in=%h ov=%b required 555557/0", bus1.add_in, bus1.out_valid);
    end
    wait_out(1, cyc);
    tests_run++;
    if (cyc !== 1 || bus1.out_sum !== 13'h1000 || bus1.acc_q !== 12'h000 ||
        bus1.ovf_sticky !== 1'b0 || s !== 13'h1000) begin
      tests_failed++;
      $display("FAIL basic_result: lat=%0d sum=%h acc=%h ovf=%b required 1/1000/000/0",
               cyc, bus1.out_sum, bus1.acc_q, bus1.ovf_sticky);
    end
    tick();
    bus1.out_ready = 1'b0;
    tests_run++;
    if (bus1.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drain: out_valid=%b required 0", bus1.out_valid);
    end
  endtask

  task automatic test_accum();
    int cyc;
    logic [12:0] s;
    logic [12:0] exp_sum [3] = '{13'h0800, 13'h1000, 13'h0800};
    logic [11:0] exp_acc [3] = '{12'h800, 12'h000, 12'h800};
    logic        exp_ovf [3] = '{1'b0, 1'b1, 1'b1};
    bus1.acc_clr = 1'b1;
    tick();
    bus1.acc_clr = 1'b0;
    mdl_clear();
    for (int k = 0; k < 3; k++) begin
      send(1, 12'h800, 12'h5A5, 1'b1);
      mdl_op(12'h800, 12'h5A5, 1'b1, s);
      wait_out(1, cyc);
      tests_run++;
      if (bus1.out_sum !== exp_sum[k] || bus1.acc_q !== exp_acc[k] ||
          bus1.ovf_sticky !== exp_ovf[k] || s !== exp_sum[k]) begin
        tests_failed++;
        $display("FAIL accum_%0d: sum=%h acc=%h ovf=%b required %h/%h/%b", k,
                 bus1.out_sum, bus1.acc_q, bus1.ovf_sticky, exp_sum[k], exp_acc[k], exp_ovf[k]);
      end
      take(1);
    end
  endtask

  task automatic test_random();
    int cyc;
    int stall;
    logic [11:0] a, b;
    logic acc;
    logic [12:0] s;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus1.acc_clr = 1'b1;
        tick();
        bus1.acc_clr = 1'b0;
        mdl_clear();
      end
      a = 12'($urandom);
      b = 12'($urandom);
      acc = 1'($urandom_range(0, 1));
      send(1, a, b, acc);
      mdl_op(a, b, acc, s);
      wait_out(1, cyc);
      tests_run++;
      if (cyc !== 1 || bus1.out_sum !== s || bus1.acc_q !== mdl_acc ||
          bus1.ovf_sticky !== mdl_ovf) begin
        tests_failed++;
        $display("FAIL random_%0d: lat=%0d sum=%h acc=%h ovf=%b required 1/%h/%h/%b", n,
                 cyc, bus1.out_sum, bus1.acc_q, bus1.ovf_sticky, s, mdl_acc, mdl_ovf);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) tick();
      tests_run++;
      if (bus1.out_valid !== 1'b1 || bus1.out_sum !== s) begin
        tests_failed++;
        $display("FAIL random_hold_%0d: ov=%b sum=%h required 1/%h", n, bus1.out_valid, bus1.out_sum, s);
      end
      take(1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [12:0] s1, s2;
    logic [11:0] a2, b2;
    a2 = 12'($urandom);
    b2 = 12'($urandom);
    send(1, 12'h3C3, 12'h0F0, 1'b0);
    mdl_op(12'h3C3, 12'h0F0, 1'b0, s1);
    wait_out(1, cyc);
    drive(1, 1'b1, a2, b2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b1 || bus1.out_sum !== s1) begin
        tests_failed++;
        $display("FAIL stall_%0d: rdy=%b ov=%b sum=%h required 0/1/%h", k,
                 bus1.in_ready, bus1.out_valid, bus1.out_sum, s1);
      end
    end
    bus1.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus1.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_ready: in_ready=%b required 1", bus1.in_ready);
    end
    tick();
    drive(1, 1'b0, '0, '0, 1'b0);
    bus1.out_ready = 1'b0;
    mdl_op(a2, b2, 1'b0, s2);
    tests_run++;
    if (bus1.out_valid !== 1'b0 || bus1.add_in !== interleave(a2, b2)) begin
      tests_failed++;
      $display("FAIL b2b_accept: ov=%b add_in=%h required 0/%h", bus1.out_valid,
               bus1.add_in, interleave(a2, b2));
    end
    wait_out(1, cyc);
    tests_run++;
    if (cyc !== 1 || bus1.out_sum !== s2) begin
      tests_failed++;
      $display("FAIL b2b_result: lat=%0d sum=%h required 1/%h", cyc, bus1.out_sum, s2);
    end
    take(1);
  endtask

  task automatic test_lat3();
    int cyc;
    logic [23:0] held;
    bit moved = 0;
    send(3, 12'h123, 12'h456, 1'b0);
    held = bus3.add_in;
    cyc = 0;
    while (!bus3.out_valid && cyc < 20) begin
      if (bus3.add_in !== held) moved = 1;
      tick();
      cyc++;
    end
    tests_run++;
    if (cyc !== 3 || bus3.out_sum !== 13'h0579 || moved || held !== interleave(12'h123, 12'h456)) begin
      tests_failed++;
      $display("FAIL lat3: lat=%0d sum=%h add_in_moved=%0d required 3/0579/0", cyc, bus3.out_sum, moved);
    end
    take(3);
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    send(3, 12'h7FF, 12'h001, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus3.out_valid !== 1'b0 || bus3.add_in !== 24'h0 || bus3.out_sum !== 13'h0 ||
        bus1.acc_q !== 12'h0 || bus1.out_sum !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: ov=%b add_in=%h sum=%h acc1=%h sum1=%h required all zero",
               bus3.out_valid, bus3.add_in, bus3.out_sum, bus1.acc_q, bus1.out_sum);
    end
    tick();
    tick();
    tests_run++;
    if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hold: ov=%b rdy=%b required 0/1", bus3.out_valid, bus3.in_ready);
    end
    #3 rst_n = 1'b1;
    mdl_clear();
    tick();
    send(3, 12'h0AB, 12'h100, 1'b0);
    wait_out(3, cyc);
    tests_run++;
    if (cyc !== 3 || bus3.out_sum !== 13'h01AB) begin
      tests_failed++;
      $display("FAIL post_reset_op: lat=%0d sum=%h required 3/01AB", cyc, bus3.out_sum);
    end
    take(3);
  endtask

  task automatic test_clr_capture();
    int cyc;
    logic [12:0] s;
    send(1, 12'hFFF, 12'h000, 1'b0);
    mdl_op(12'hFFF, 12'h000, 1'b0, s);
    wait_out(1, cyc);
    take(1);
    send(1, 12'h002, 12'h123, 1'b1);
    bus1.acc_clr = 1'b1;
    wait_out(1, cyc);
    bus1.acc_clr = 1'b0;
    mdl_op(12'h002, 12'h123, 1'b1, s);
    mdl_clear();
    tests_run++;
    if (bus1.out_sum !== 13'h1001 || s !== 13'h1001 || bus1.acc_q !== 12'h000 ||
        bus1.ovf_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_capture: sum=%h acc=%h ovf=%b required 1001/000/0",
               bus1.out_sum, bus1.acc_q, bus1.ovf_sticky);
    end
    take(1);
    send(1, 12'h0AA, 12'h011, 1'b0);
    mdl_op(12'h0AA, 12'h011, 1'b0, s);
    wait_out(1, cyc);
    take(1);
    bus1.acc_clr = 1'b1;
    send(1, 12'h300, 12'h7FF, 1'b1);
    bus1.acc_clr = 1'b0;
    mdl_clear();
    tests_run++;
    if (bus1.add_in !== interleave(12'h300, 12'h000)) begin
      tests_failed++;
      $display("FAIL clr_accept_opb: add_in=%h required %h", bus1.add_in, interleave(12'h300, 12'h000));
    end
    mdl_op(12'h300, 12'h7FF, 1'b1, s);
    wait_out(1, cyc);
    tests_run++;
    if (bus1.out_sum !== s || bus1.acc_q !== mdl_acc || bus1.ovf_sticky !== mdl_ovf) begin
      tests_failed++;
      $display("FAIL clr_accept_result: sum=%h acc=%h ovf=%b required %h/%h/%b",
               bus1.out_sum, bus1.acc_q, bus1.ovf_sticky, s, mdl_acc, mdl_ovf);
    end
    take(1);
  endtask

  initial begin
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(3, 1'b0, '0, '0, 1'b0);
    bus1.acc_clr = 1'b0;  bus3.acc_clr = 1'b0;
    bus1.out_ready = 1'b0; bus3.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_accum();
    test_random();
    test_back_to_back();
    test_lat3();
    test_reset_mid_wait();
    test_clr_capture();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
